// File: rtl/ripple_count_sampler.sv
// Samples an async ripple-counter bus, accepts values stable for STABLE_CYCLES and pulses change/match/wrap.
// Latency: SYNC_STAGES+STABLE_CYCLES+1 clk from settled input to count_out; no backpressure, events are fire-and-forget.
module ripple_count_sampler #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int WRAP_W        = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic [WIDTH-1:0]  count_in,
  input  logic [WIDTH-1:0]  match_value,
  input  logic              match_en,
  output logic [WIDTH-1:0]  count_out,
  output logic              count_valid,
  output logic              change_pulse,
  output logic              match_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {INIT, TRACK, SETTLE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [SYNC_STAGES:0] fill;
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] prev;
  logic [SW-1:0]    stab_cnt;
  logic             same;
  logic             stable;
  logic             accept;
  logic             wrap;

  // fill marks which pipeline stages hold real samples since clear, so reset zeros never count as stable
  assign synced = sync_q[SYNC_STAGES-1];
  assign same   = fill[SYNC_STAGES] && (synced == prev);
  assign stable = same && (stab_cnt == STAB_LAST);
  assign accept = stable && ((state == INIT) || (synced != count_out));
  assign wrap   = (state != INIT) && (synced < count_out);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      fill     <= '0;
      prev     <= '0;
      stab_cnt <= '0;
    end else begin
      sync_q[0] <= count_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill <= {fill[SYNC_STAGES-1:0], 1'b1};
      prev <= synced;
      if (!same)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state        <= INIT;
      count_out    <= '0;
      count_valid  <= 1'b0;
      change_pulse <= 1'b0;
      match_pulse  <= 1'b0;
      wrap_pulse   <= 1'b0;
      wrap_count   <= '0;
    end else begin
      change_pulse <= accept;
      match_pulse  <= accept && match_en && (synced == match_value);
      wrap_pulse   <= accept && wrap;
      if (accept) begin
        count_out   <= synced;
        count_valid <= 1'b1;
        if (wrap && (wrap_count != '1))
          wrap_count <= wrap_count + 1'b1;
      end
      case (state)
        INIT:    if (accept) state <= TRACK;
        TRACK:   if (!accept && (synced != count_out)) state <= SETTLE;
        // a candidate that collapses back to the published value is a rejected glitch
        SETTLE:  if (accept || (stable && (synced == count_out))) state <= TRACK;
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Randomized bench for ripple_count_sampler: a run-length reference model predicts every output each cycle,
// with a second instance at WRAP_W=2 for wrap-counter saturation.
module tb_ripple_count_sampler;

  localparam int D = 2;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] count_in;
  logic [3:0] match_value;
  logic       match_en;

  logic [3:0] count_out, count_out2;
  logic       count_valid, count_valid2;
  logic       change_pulse, change_pulse2;
  logic       match_pulse, match_pulse2;
  logic       wrap_pulse, wrap_pulse2;
  logic [7:0] wrap_count;
  logic [1:0] wrap_count2;

  always #5 clk = ~clk;

  ripple_count_sampler #(.WIDTH(4), .SYNC_STAGES(D), .STABLE_CYCLES(S), .WRAP_W(8)) u_dut (
    .clk(clk), .clear(clear), .count_in(count_in), .match_value(match_value), .match_en(match_en),
    .count_out(count_out), .count_valid(count_valid), .change_pulse(change_pulse),
    .match_pulse(match_pulse), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count)
  );

  ripple_count_sampler #(.WIDTH(4), .SYNC_STAGES(D), .STABLE_CYCLES(S), .WRAP_W(2)) u_dut_w2 (
    .clk(clk), .clear(clear), .count_in(count_in), .match_value(match_value), .match_en(match_en),
    .count_out(count_out2), .count_valid(count_valid2), .change_pulse(change_pulse2),
    .match_pulse(match_pulse2), .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: a value is published D edges after it completes a run of exactly S+1 equal samples
  int last_val, run, nsamp;
  int vq[$];
  int rq[$];
  int e_out, e_valid, e_change, e_match, e_wrap, e_wc, e_wc2;
  int wrap2_seen;
  int cur;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    nsamp = 0; run = 0; last_val = 0;
    vq.delete(); rq.delete();
    e_out = 0; e_valid = 0; e_change = 0; e_match = 0; e_wrap = 0; e_wc = 0; e_wc2 = 0;
  endtask

  task automatic model_edge();
    int v, r;
    if (nsamp > 0 && int'(count_in) == last_val) run = (run < 1000) ? run + 1 : run;
    else run = 1;
    last_val = int'(count_in);
    nsamp++;
    vq.push_back(int'(count_in));
    rq.push_back(run);
    e_change = 0; e_match = 0; e_wrap = 0;
    if (vq.size() == D + 1) begin
      v = vq.pop_front();
      r = rq.pop_front();
      if (r == S + 1 && (e_valid == 0 || v != e_out)) begin
        e_change = 1;
        e_match  = (match_en && v == int'(match_value)) ? 1 : 0;
        if (e_valid != 0 && v < e_out) begin
          e_wrap = 1;
          if (e_wc < 255) e_wc++;
          if (e_wc2 < 3) e_wc2++;
        end
        e_out = v;
        e_valid = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("count_out", count_out, e_out);
    chk("count_valid", count_valid, e_valid);
    chk("change_pulse", change_pulse, e_change);
    chk("match_pulse", match_pulse, e_match);
    chk("wrap_pulse", wrap_pulse, e_wrap);
    chk("wrap_count", wrap_count, e_wc);
    chk("count_out_w2", count_out2, e_out);
    chk("wrap_pulse_w2", wrap_pulse2, e_wrap);
    chk("wrap_count_w2", wrap_count2, e_wc2);
    if (wrap_pulse2) wrap2_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (clear) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input int v, input int n);
    count_in = 4'(v);
    cur = v;
    repeat (n) tick();
  endtask

  // called at a negedge; outputs must drop immediately, release one cycle later
  task automatic do_clear();
    clear = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    clear = 1'b1;
  endtask

  initial begin
    int mode;
    clear = 1'b0; count_in = '0; match_value = '0; match_en = 1'b0;
    cur = 0; wrap2_seen = 0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    clear = 1'b1;

    // first value: visible only at edge 5
    hold(0, 10);
    chk("first_accept_out", count_out, 0);
    chk("first_accept_valid", count_valid, 1);

    match_value = 4'd1; match_en = 1'b1;
    hold(1, 8);
    chk("step_out", count_out, 1);
    match_en = 1'b0; match_value = 4'd2;
    hold(2, 8);

    hold(3, 8);
    hold(2, 1);
    hold(3, 8);
    chk("glitch_out", count_out, 3);

    do_clear();
    wrap2_seen = 0;
    match_value = 4'd0; match_en = 1'b1;
    for (int v = 0; v < 16; v++) hold(v, 8);
    hold(0, 8);
    chk("sweep_wrap_count", wrap_count, 1);
    for (int k = 0; k < 4; k++) begin
      hold(15, 6);
      hold(0, 6);
    end
    chk("five_wraps_w8", wrap_count, 5);
    chk("five_wraps_w2", wrap_count2, 3);
    chk("five_wrap_pulses_w2", wrap2_seen, 5);

    hold(7, 8);
    hold(8, 3);
    do_clear();
    hold(8, 10);
    chk("post_clear_out", count_out, 8);

    for (int it = 0; it < 400; it++) begin
      mode = $urandom_range(0, 29);
      if (mode < 16) begin
        hold($urandom_range(0, 15), $urandom_range(1, 8));
      end else if (mode < 22) begin
        mode = cur;
        hold($urandom_range(0, 15), $urandom_range(1, 2));
        hold(mode, $urandom_range(1, 6));
      end else if (mode < 26) begin
        hold((cur + 1) % 16, $urandom_range(3, 6));
      end else if (mode < 29) begin
        match_value = 4'($urandom_range(0, 15));
        match_en = 1'($urandom_range(0, 1));
        tick();
      end else begin
        do_clear();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
